// File: rtl/lane_row_renderer_if.sv
// Handshake and pixel bus between the game FSM (master) and lane_row_renderer (slave).
// The master sends frame requests and row data; the slave returns one plot pixel per clock.
interface lane_row_renderer_if #(
  parameter int NUM_ROWS = 4
);
  logic                    start;
  logic [3*NUM_ROWS-1:0]   row_codes;
  logic [5:0]              offset;
  logic [8:0]              x_out;
  logic [7:0]              y_out;
  logic [2:0]              c_out;
  logic                    plot;
  logic                    busy;
  logic                    all_done;

  modport master (
    output start, row_codes, offset,
    input  x_out, y_out, c_out, plot, busy, all_done
  );

  modport slave (
    input  start, row_codes, offset,
    output x_out, y_out, c_out, plot, busy, all_done
  );
endinterface

// File: rtl/lane_row_renderer.sv
// Multi-row note renderer: per frame, erases each row's previous segment and draws the new one.
// Optional macro LANE_COLOUR_EN selects per-column draw colours; otherwise segments are white.
module lane_row_renderer #(
  parameter int NUM_ROWS  = 4,
  parameter int ROW_PITCH = 40,
  parameter int SEG_WIDTH = 20,
  parameter int X_BASE    = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  lane_row_renderer_if.slave   bus
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PW = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;
  localparam int CW = 3 * NUM_ROWS;
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(SEG_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row;
  logic [PW-1:0]   pix;
  logic [CW-1:0]   pend_codes, shadow_codes;
  logic [5:0]      pend_off, shadow_off;

  logic [2:0]      cur_code;
  logic [5:0]      cur_off;
  logic [9:0]      cur_y;
  logic            cur_valid;
  logic            seg_last;

  function automatic logic [2:0] draw_colour(input logic [2:0] code);
`ifdef LANE_COLOUR_EN
    case (code)
      3'd1:    return 3'b010;
      3'd2:    return 3'b100;
      3'd3:    return 3'b110;
      3'd4:    return 3'b001;
      default: return 3'b000;
    endcase
`else
    return (code != 3'd0) ? 3'b111 : 3'b000;
`endif
  endfunction

  // Segment currently being walked: erase uses the shadow frame, draw uses the pending one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_code = 3'd0;
    cur_off  = 6'd0;
    if (state == S_ERASE) begin
      cur_code = shadow_codes[3*int'(row) +: 3];
      cur_off  = shadow_off;
    end else if (state == S_DRAW) begin
      cur_code = pend_codes[3*int'(row) +: 3];
      cur_off  = pend_off;
    end
    // y is formed 10 bits wide so rows pushed past the bottom compare correctly.
    cur_y     = 10'(int'(row) * ROW_PITCH) + 10'(cur_off);
    cur_valid = ((state == S_ERASE) || (state == S_DRAW)) &&
                (cur_code >= 3'd1) && (cur_code <= 3'd4) &&
                (cur_y < 10'd240);
    // An invalid segment occupies exactly one cycle.
    seg_last  = !cur_valid || (pix == LAST_PIX);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ERASE;
      S_ERASE: if (seg_last) state_nxt = S_DRAW;
      S_DRAW:  if (seg_last) state_nxt = (row == LAST_ROW) ? S_DONE : S_ERASE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      row          <= '0;
      pix          <= '0;
      pend_codes   <= '0;
      pend_off     <= '0;
      // NOTE: the shadow frame is reset too, so the first frame after reset erases nothing.
      shadow_codes <= '0;
      shadow_off   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          pend_codes <= bus.row_codes;
          pend_off   <= bus.offset;
          row        <= '0;
          pix        <= '0;
        end
        S_ERASE: begin
          pix <= seg_last ? '0 : pix + 1'b1;
        end
        S_DRAW: begin
          pix <= seg_last ? '0 : pix + 1'b1;
          if (seg_last && (row != LAST_ROW)) row <= row + 1'b1;
        end
        S_DONE: begin
          shadow_codes <= pend_codes;
          shadow_off   <= pend_off;
        end
        default: ;
      endcase
    end
  end

  // Moore pixel outputs: derived from the registered state, row and pixel counter.
  always_comb begin
    bus.plot  = 1'b0;
    bus.x_out = 9'd0;
    bus.y_out = 8'd0;
    bus.c_out = 3'b000;
    if (cur_valid) begin
      bus.plot  = 1'b1;
      bus.x_out = 9'(X_BASE + (int'(cur_code) - 1) * SEG_WIDTH + int'(pix));
      bus.y_out = cur_y[7:0];
      if (state == S_DRAW) bus.c_out = draw_colour(cur_code);
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.all_done = (state == S_DONE);

endmodule

// File: tb/tb_lane_row_renderer.sv
// Self-checking bench for lane_row_renderer: a cycle-level frame model built from the
// erase/draw rules, checked against a 4-row and a 6-row instance.
module tb_lane_row_renderer;

  typedef struct packed {
    logic       plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       busy;
    logic       done;
  } pix_t;

  typedef int codes_t[8];

  logic clk = 1'b0;
  logic reset4, reset6;
  always #5 clk = ~clk;

  lane_row_renderer_if #(.NUM_ROWS(4)) bus4 ();
  lane_row_renderer_if #(.NUM_ROWS(6)) bus6 ();

  lane_row_renderer #(.NUM_ROWS(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4.slave));
  lane_row_renderer #(.NUM_ROWS(6)) dut6 (.clk(clk), .reset(reset6), .bus(bus6.slave));

  int vectors = 0;
  int errors  = 0;

  int   sh_code[2][8];
  int   sh_off[2];
  int   rows_of[2] = '{4, 6};
  pix_t exp_q[$];

  function automatic int colour_of(input int code);
`ifdef LANE_COLOUR_EN
    case (code)
      1: return 2;
      2: return 4;
      3: return 6;
      default: return 1;
    endcase
`else
    return (code >= 1) ? 7 : 0;
`endif
  endfunction

  function automatic pix_t mk(input bit plot, input int x, input int y, input int c,
                              input bit busy, input bit done);
    pix_t p;
    p.plot = plot; p.x = 9'(x); p.y = 8'(y); p.c = 3'(c); p.busy = busy; p.done = done;
    return p;
  endfunction

  function automatic void push_seg(input int row, input int code, input int off, input bit draw);
    int y = row * 40 + off;
    if (code >= 1 && code <= 4 && y < 240) begin
      for (int i = 0; i < 20; i++)
        exp_q.push_back(mk(1, 120 + (code - 1) * 20 + i, y, draw ? colour_of(code) : 0, 1, 0));
    end else begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
    end
  endfunction

  // Expected cycles LOAD..DONE for one frame; the model's shadow becomes the new frame.
  function automatic void build_frame(input int sel, input codes_t pc, input int po);
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
    for (int r = 0; r < rows_of[sel]; r++) begin
      push_seg(r, sh_code[sel][r], sh_off[sel], 0);
      push_seg(r, pc[r], po, 1);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1));
    for (int r = 0; r < 8; r++) sh_code[sel][r] = pc[r];
    sh_off[sel] = po;
  endfunction

  function automatic void clear_shadow(input int sel);
    for (int r = 0; r < 8; r++) sh_code[sel][r] = 0;
    sh_off[sel] = 0;
  endfunction

  function automatic pix_t sample(input int sel);
    if (sel == 0) return {bus4.plot, bus4.x_out, bus4.y_out, bus4.c_out, bus4.busy, bus4.all_done};
    return {bus6.plot, bus6.x_out, bus6.y_out, bus6.c_out, bus6.busy, bus6.all_done};
  endfunction

  function automatic codes_t rand_codes(input int lo, input int hi);
    codes_t c;
    for (int r = 0; r < 8; r++) c[r] = int'($urandom_range(hi, lo));
    return c;
  endfunction

  function automatic codes_t zero_codes();
    codes_t c;
    for (int r = 0; r < 8; r++) c[r] = 0;
    return c;
  endfunction

  task automatic drive(input int sel, input bit st, input codes_t pc, input int po);
    logic [23:0] v = '0;
    for (int r = 0; r < 8; r++) v[3*r +: 3] = 3'(pc[r]);
    if (sel == 0) begin
      bus4.start = st; bus4.row_codes = v[11:0]; bus4.offset = 6'(po);
    end else begin
      bus6.start = st; bus6.row_codes = v[17:0]; bus6.offset = 6'(po);
    end
  endtask

  // Called at a negedge while IDLE: start is sampled at the next edge.
  task automatic start_frame(input int sel, input codes_t pc, input int po);
    drive(sel, 1'b1, pc, po);
    @(negedge clk);
  endtask

  // Called at the negedge of the LOAD cycle. Walks the whole frame, then checks the IDLE cycle.
  task automatic run_frame(input string name, input int sel, input codes_t pc, input int po,
                           input bit glitch, input bit chain, input codes_t npc, input int npo);
    pix_t got;
    build_frame(sel, pc, po);
    for (int k = 0; k < exp_q.size(); k++) begin
      got = sample(sel);
      vectors++;
      if (got !== exp_q[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: got plot=%b x=%0d y=%0d c=%b busy=%b done=%b, want plot=%b x=%0d y=%0d c=%b busy=%b done=%b",
                 name, k, got.plot, got.x, got.y, got.c, got.busy, got.done,
                 exp_q[k].plot, exp_q[k].x, exp_q[k].y, exp_q[k].c, exp_q[k].busy, exp_q[k].done);
      end
      if (k == 0) drive(sel, glitch ? 1'($urandom_range(1, 0)) : 1'b0, pc, po);
      else if (glitch) drive(sel, 1'($urandom_range(1, 0)), rand_codes(0, 7), int'($urandom_range(63, 0)));
      @(negedge clk);
    end
    got = sample(sel);
    vectors++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s idle-after-done: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b, want all zero",
               name, got.plot, got.busy, got.done, got.x, got.y, got.c);
    end
    if (chain) begin
      drive(sel, 1'b1, npc, npo);
      @(negedge clk);
    end else begin
      drive(sel, 1'b0, pc, po);
    end
  endtask

  task automatic frame(input string name, input int sel, input codes_t pc, input int po);
    start_frame(sel, pc, po);
    run_frame(name, sel, pc, po, 1'b0, 1'b0, pc, po);
  endtask

  task automatic test_reset();
    pix_t got;
    reset4 = 1'b1; reset6 = 1'b1;
    drive(0, 1'b1, rand_codes(0, 7), 5);
    drive(1, 1'b1, rand_codes(0, 7), 5);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      got = sample(s);
      vectors++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b, want all zero",
                 rows_of[s], got.plot, got.busy, got.done, got.x, got.y, got.c);
      end
      clear_shadow(s);
      drive(s, 1'b0, zero_codes(), 0);
    end
    reset4 = 1'b0; reset6 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_row();
    codes_t pc = zero_codes();
    pc[0] = 2;
    frame("single_row", 0, pc, 5);
  endtask

  task automatic test_follow();
    codes_t pc = zero_codes();
    pc[0] = 3;
    frame("follow_erase", 0, pc, 6);
  endtask

  task automatic test_offscreen();
    codes_t pc = zero_codes();
    pc[5] = 1;
    frame("offscreen_row5", 1, pc, 45);
  endtask

  task automatic test_empty_codes();
    frame("empty_codes", 1, rand_codes(5, 7), int'($urandom_range(63, 0)));
  endtask

  task automatic test_row_boundary();
    codes_t pc = zero_codes();
    pc[5] = 2;
    frame("y_239", 1, pc, 39);
    frame("y_240", 1, pc, 40);
  endtask

  task automatic test_start_ignored();
    codes_t pc = rand_codes(0, 4);
    start_frame(0, pc, int'($urandom_range(63, 0)));
    run_frame("start_while_busy", 0, pc, int'(bus4.offset), 1'b1, 1'b0, pc, 0);
  endtask

  task automatic test_colours();
    codes_t pc = zero_codes();
    for (int r = 0; r < 4; r++) pc[r] = r + 1;
    frame("colours", 0, pc, int'($urandom_range(63, 0)));
  endtask

  task automatic test_mid_reset();
    codes_t pc = zero_codes();
    pix_t got;
    int stop = -1;
    pc[0] = 1; pc[2] = 4;
    start_frame(0, pc, 0);
    build_frame(0, pc, 0);
    for (int k = 0; k < exp_q.size() && stop < 0; k++)
      if (exp_q[k].plot && exp_q[k].c != 3'b000) stop = k + 10;
    drive(0, 1'b0, pc, 0);
    for (int k = 0; k <= stop; k++) begin
      got = sample(0);
      vectors++;
      if (got !== exp_q[k]) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d: got plot=%b x=%0d y=%0d c=%b, want plot=%b x=%0d y=%0d c=%b",
                 k, got.plot, got.x, got.y, got.c, exp_q[k].plot, exp_q[k].x, exp_q[k].y, exp_q[k].c);
      end
      if (k == stop) reset4 = 1'b1;
      @(negedge clk);
    end
    got = sample(0);
    vectors++;
    if (got !== '0) begin
      errors++;
      $display("FAIL mid_reset_post: got plot=%b busy=%b done=%b x=%0d, want all zero",
               got.plot, got.busy, got.done, got.x);
    end
    reset4 = 1'b0;
    clear_shadow(0);
    frame("after_reset", 0, rand_codes(0, 4), int'($urandom_range(63, 0)));
  endtask

  task automatic test_back_to_back();
    codes_t a = rand_codes(0, 4);
    codes_t b = rand_codes(0, 4);
    codes_t c = rand_codes(0, 7);
    int oa = int'($urandom_range(63, 0));
    int ob = int'($urandom_range(63, 0));
    int oc = int'($urandom_range(63, 0));
    start_frame(0, a, oa);
    run_frame("b2b_1", 0, a, oa, 1'b0, 1'b1, b, ob);
    run_frame("b2b_2", 0, b, ob, 1'b0, 1'b1, c, oc);
    run_frame("b2b_3", 0, c, oc, 1'b0, 1'b0, c, oc);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int s = i % 2;
      frame("random", s, rand_codes(0, 7), int'($urandom_range(63, 0)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_row();
    test_follow();
    test_offscreen();
    test_empty_codes();
    test_row_boundary();
    test_start_ignored();
    test_colours();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
